// File: rtl/tx_lane_arbiter_pkg.sv
// Shared types and constants for the PHY transmit lane arbiter.
package tx_lane_arbiter_pkg;

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam logic [7:0]  IDLE_BYTE_DEF = 8'hBC;
  localparam int unsigned DROP_CNT_W    = 8;

  // Adds 0..2 dropped bytes to the drop counter, clamping at all-ones.
  function automatic logic [DROP_CNT_W-1:0] sat_add_drop(
    input logic [DROP_CNT_W-1:0] cnt,
    input logic [1:0]            inc
  );
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(DROP_CNT_W-1){1'b0}}, inc};
    return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/tx_lane_arbiter_if.sv
// Lane inputs, merged byte stream and status of the transmit lane arbiter.
interface tx_lane_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  import tx_lane_arbiter_pkg::*;

  logic [DATA_W-1:0]     data_in0;
  logic                  valid_in0;
  logic [DATA_W-1:0]     data_in1;
  logic                  valid_in1;
  logic                  ready_out0;
  logic                  ready_out1;
  logic                  out_ready;
  logic [DATA_W-1:0]     data_out;
  logic                  valid_out;
  logic                  lane_out;
  logic                  active_out;
  logic [DROP_CNT_W-1:0] drop_cnt;

  modport master (
    output data_in0, valid_in0, data_in1, valid_in1, out_ready,
    input  ready_out0, ready_out1, data_out, valid_out, lane_out,
           active_out, drop_cnt
  );

  modport slave (
    input  data_in0, valid_in0, data_in1, valid_in1, out_ready,
    output ready_out0, ready_out1, data_out, valid_out, lane_out,
           active_out, drop_cnt
  );

endinterface

// File: rtl/tx_lane_fifo.sv
// Per-lane synchronous FIFO; push is refused when full, pop when empty.
module tx_lane_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                    clk_2f,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-1:0]       head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  // Full is taken from the registered count, so a full FIFO refuses a
  // write even when it also pops in the same cycle.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/tx_lane_arbiter.sv
// Two-lane to one-byte-stream scheduler: per-lane FIFOs, link-start idle
// sequence, then round-robin merge under downstream backpressure.
module tx_lane_arbiter
  import tx_lane_arbiter_pkg::*;
#(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       DEPTH       = 4,
  parameter logic [DATA_W-1:0] IDLE_BYTE   = DATA_W'(IDLE_BYTE_DEF),
  parameter int unsigned       SYNC_CYCLES = 4
) (
  input  logic             clk_2f,
  input  logic             reset,
  tx_lane_arbiter_if.slave lanes
);
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned SYNC_W = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_CYCLES - 1);

  state_e                state_q, state_d;
  logic [SYNC_W-1:0]     sync_cnt_q, sync_cnt_d;
  logic                  last_grant_q, last_grant_d;
  logic [DATA_W-1:0]     data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  lane_out_q, lane_out_d;
  logic                  active_q, active_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic              push0, pop0, full0, empty0;
  logic              push1, pop1, full1, empty1;
  logic [DATA_W-1:0] head0, head1;
  logic [CNT_W-1:0]  count0, count1;
  logic              grant;
  logic              drop0, drop1;

  tx_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk_2f (clk_2f),
    .reset  (reset),
    .push   (push0),
    .pop    (pop0),
    .din    (lanes.data_in0),
    .head   (head0),
    .count  (count0),
    .full   (full0),
    .empty  (empty0)
  );

  tx_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk_2f (clk_2f),
    .reset  (reset),
    .push   (push1),
    .pop    (pop1),
    .din    (lanes.data_in1),
    .head   (head1),
    .count  (count1),
    .full   (full1),
    .empty  (empty1)
  );

  assign lanes.ready_out0 = !full0;
  assign lanes.ready_out1 = !full1;
  assign lanes.data_out   = data_out_q;
  assign lanes.valid_out  = valid_out_q;
  assign lanes.lane_out   = lane_out_q;
  assign lanes.active_out = active_q;
  assign lanes.drop_cnt   = drop_cnt_q;

  always_comb begin
    push0        = lanes.valid_in0 && !full0;
    push1        = lanes.valid_in1 && !full1;
    drop0        = lanes.valid_in0 && full0;
    drop1        = lanes.valid_in1 && full1;
    drop_cnt_d   = sat_add_drop(drop_cnt_q, {1'b0, drop0} + {1'b0, drop1});
    pop0         = 1'b0;
    pop1         = 1'b0;
    grant        = 1'b0;
    state_d      = state_q;
    sync_cnt_d   = sync_cnt_q;
    last_grant_d = last_grant_q;
    data_out_d   = data_out_q;
    valid_out_d  = valid_out_q;
    lane_out_d   = lane_out_q;

    // Backpressure freezes outputs, arbitration history and the sync count.
    if (lanes.out_ready) begin
      unique case (state_q)
        ST_SYNC: begin
          data_out_d  = IDLE_BYTE;
          valid_out_d = 1'b0;
          if (sync_cnt_q == SYNC_LAST) begin
            state_d = ST_ACTIVE;
          end else begin
            sync_cnt_d = sync_cnt_q + SYNC_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (!empty0 || !empty1) begin
            grant        = (!empty0 && !empty1) ? !last_grant_q : empty0;
            pop0         = !grant;
            pop1         = grant;
            data_out_d   = grant ? head1 : head0;
            valid_out_d  = 1'b1;
            lane_out_d   = grant;
            last_grant_d = grant;
          end else begin
            data_out_d  = IDLE_BYTE;
            valid_out_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    active_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      state_q      <= ST_SYNC;
      sync_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      data_out_q   <= IDLE_BYTE;
      valid_out_q  <= 1'b0;
      lane_out_q   <= 1'b0;
      active_q     <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      sync_cnt_q   <= sync_cnt_d;
      last_grant_q <= last_grant_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      lane_out_q   <= lane_out_d;
      active_q     <= active_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // The FIFO's empty flag and its count must always agree.
  a_fifo_flags: assert property (@(posedge clk_2f) disable iff (!reset)
    (empty0 == (count0 == '0)) && (empty1 == (count1 == '0)));

endmodule

// File: tb/tb_tx_lane_arbiter.sv
// Directed self-checking bench for tx_lane_arbiter.
module tb_tx_lane_arbiter;

  logic clk_2f;
  logic reset;
  int   n_checks;
  int   n_errors;

  tx_lane_arbiter_if #(.DATA_W(8)) bus ();

  tx_lane_arbiter #(
    .DATA_W      (8),
    .DEPTH       (4),
    .IDLE_BYTE   (8'hBC),
    .SYNC_CYCLES (4)
  ) dut (
    .clk_2f (clk_2f),
    .reset  (reset),
    .lanes  (bus)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                           input logic l);
    check_eq({tag, ".valid"}, 32'(bus.valid_out), 32'(v));
    check_eq({tag, ".data"},  32'(bus.data_out),  32'(d));
    check_eq({tag, ".lane"},  32'(bus.lane_out),  32'(l));
  endtask

  task automatic step();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic run_sync(input string tag);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_eq($sformatf("%s.sync%0d.valid", tag, i), 32'(bus.valid_out), 32'd0);
      check_eq($sformatf("%s.sync%0d.data", tag, i), 32'(bus.data_out), 32'hBC);
      check_eq($sformatf("%s.sync%0d.active", tag, i), 32'(bus.active_out),
               32'(i == 4));
    end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b0;
    bus.data_in0  = '0;
    bus.valid_in0 = 1'b0;
    bus.data_in1  = '0;
    bus.valid_in1 = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values
    step();
    step();
    check_out("rst", 1'b0, 8'hBC, 1'b0);
    check_eq("rst.active", 32'(bus.active_out), 32'd0);
    check_eq("rst.drop", 32'(bus.drop_cnt), 32'd0);
    check_eq("rst.ready0", 32'(bus.ready_out0), 32'd1);
    check_eq("rst.ready1", 32'(bus.ready_out1), 32'd1);

    // Link-start sequence
    reset = 1'b1;
    run_sync("boot");
    step();
    check_out("boot.idle", 1'b0, 8'hBC, 1'b0);
    check_eq("boot.active_hold", 32'(bus.active_out), 32'd1);

    // Both lanes backlogged: strict alternation starting with lane 0
    bus.data_in0 = 8'h11; bus.valid_in0 = 1'b1;
    bus.data_in1 = 8'hA1; bus.valid_in1 = 1'b1;
    step();
    check_out("rr.empty", 1'b0, 8'hBC, 1'b0);
    bus.data_in0 = 8'h22;
    bus.data_in1 = 8'hA2;
    step();
    check_out("rr.b0", 1'b1, 8'h11, 1'b0);
    bus.valid_in0 = 1'b0;
    bus.valid_in1 = 1'b0;
    step();
    check_out("rr.b1", 1'b1, 8'hA1, 1'b1);
    step();
    check_out("rr.b2", 1'b1, 8'h22, 1'b0);
    step();
    check_out("rr.b3", 1'b1, 8'hA2, 1'b1);
    step();
    check_out("rr.idle", 1'b0, 8'hBC, 1'b1);

    // Lane 0 overflow while stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.data_in0  = 8'(i + 1);
      bus.valid_in0 = 1'b1;
      step();
      check_eq($sformatf("ovf.ready0_%0d", i), 32'(bus.ready_out0), 32'(i < 3));
    end
    bus.valid_in0 = 1'b0;
    check_eq("ovf.drop", 32'(bus.drop_cnt), 32'd2);
    check_out("ovf.stalled", 1'b0, 8'hBC, 1'b1);

    // Release: a write on the popping edge of a full FIFO is still refused
    bus.out_ready = 1'b1;
    bus.data_in0  = 8'h07;
    bus.valid_in0 = 1'b1;
    step();
    bus.valid_in0 = 1'b0;
    check_out("ovf.o1", 1'b1, 8'h01, 1'b0);
    check_eq("ovf.full_pop_drop", 32'(bus.drop_cnt), 32'd3);
    check_eq("ovf.ready0_after", 32'(bus.ready_out0), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      step();
      check_out($sformatf("ovf.o%0d", i), 1'b1, 8'(i), 1'b0);
    end
    step();
    check_out("ovf.idle", 1'b0, 8'hBC, 1'b0);

    // Stall in the middle of a lane 1 burst
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.data_in1  = 8'hB1 + 8'(i);
      bus.valid_in1 = 1'b1;
      step();
    end
    bus.valid_in1 = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check_out("stall.b1", 1'b1, 8'hB1, 1'b1);
    bus.out_ready = 1'b0;
    step();
    check_out("stall.hold", 1'b1, 8'hB1, 1'b1);
    bus.out_ready = 1'b1;
    step();
    check_out("stall.b2", 1'b1, 8'hB2, 1'b1);
    step();
    check_out("stall.b3", 1'b1, 8'hB3, 1'b1);
    step();
    check_out("stall.idle", 1'b0, 8'hBC, 1'b1);

    // Reset with bytes queued
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.data_in0  = 8'hC1 + 8'(i);
      bus.valid_in0 = 1'b1;
      step();
    end
    bus.valid_in0 = 1'b0;
    reset = 1'b0;
    step();
    check_out("mrst", 1'b0, 8'hBC, 1'b0);
    check_eq("mrst.active", 32'(bus.active_out), 32'd0);
    check_eq("mrst.drop", 32'(bus.drop_cnt), 32'd0);
    check_eq("mrst.ready0", 32'(bus.ready_out0), 32'd1);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    run_sync("mrst");
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("mrst.flushed%0d", i), 1'b0, 8'hBC, 1'b0);
    end

    // Simultaneous drops on both lanes, then saturation
    bus.out_ready = 1'b0;
    bus.data_in0  = 8'h55; bus.valid_in0 = 1'b1;
    bus.data_in1  = 8'h66; bus.valid_in1 = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check_eq("sat.dual_drop", 32'(bus.drop_cnt), 32'd2);
    check_eq("sat.ready0", 32'(bus.ready_out0), 32'd0);
    check_eq("sat.ready1", 32'(bus.ready_out1), 32'd0);
    bus.valid_in0 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 251) check_eq("sat.254", 32'(bus.drop_cnt), 32'd254);
    end
    bus.valid_in1 = 1'b0;
    check_eq("sat.255", 32'(bus.drop_cnt), 32'd255);
    bus.out_ready = 1'b1;
    step();
    check_out("sat.first", 1'b1, 8'h55, 1'b0);
    step();
    check_out("sat.second", 1'b1, 8'h66, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tx_lane_arbiter.md
# tx_lane_arbiter

Two-lane to one-byte-stream scheduler for the PHY transmit path, clocked at clk_2f. It buffers the two registered byte lanes (data/valid pairs) in per-lane FIFOs, runs a link-start sequence of idle symbols, then merges the lanes onto a single byte stream with round-robin fairness and downstream backpressure. It sits directly after the lane register stage and feeds the serializer.

## Interface
- DATA_W, 8, lane and output byte width
- DEPTH, 4, per-lane FIFO depth; power of two, at least 2
- IDLE_BYTE, 8'hBC, symbol driven on data_out when no byte is granted
- SYNC_CYCLES, 4, idle cycles emitted after reset before the ACTIVE state; at least 1
- clk_2f  in  1  clock; all logic on posedge
- reset  in  1  reset, synchronous, active-low; clock clk_2f
- data_in0  in  DATA_W  lane 0 byte
- valid_in0  in  1  lane 0 byte valid
- data_in1  in  DATA_W  lane 1 byte
- valid_in1  in  1  lane 1 byte valid
- ready_out0  out  1  lane 0 FIFO not full; combinational from count
- ready_out1  out  1  lane 1 FIFO not full
- out_ready  in  1  downstream accepts data_out this cycle
- data_out  out  DATA_W  merged byte, registered
- valid_out  out  1  data_out carries a lane byte, registered
- lane_out  out  1  source lane of data_out, registered
- active_out  out  1  state is ACTIVE, registered
- drop_cnt  out  8  count of bytes refused on full FIFOs; saturates at 255

## Operation
- States are SYNC and ACTIVE. Reset enters SYNC with sync counter 0. SYNC moves to ACTIVE when the counter reaches SYNC_CYCLES-1, and the counter advances only while out_ready=1. ACTIVE is held until reset.
- Write: each lane pushes when valid_inN=1 and countN<DEPTH. Push happens in both states.
- Drop: valid_inN=1 with countN==DEPTH discards the byte and increments drop_cnt by 1. Two lanes dropping in the same cycle add 2, saturating at 255.
- Full is evaluated on the count before any same-cycle pop. A full FIFO refuses the write even if it pops in that cycle.
- Arbitration in ACTIVE with out_ready=1:
  - Eligible lanes are those with count>0.
  - With both eligible, the grant goes to the lane other than last_grant. With one eligible, that lane is granted.
  - The granted lane pops. Outputs load head byte, valid_out=1, lane_out=lane. last_grant updates.
  - With none eligible: data_out=IDLE_BYTE, valid_out=0, lane_out holds, last_grant holds.
- In SYNC with out_ready=1: data_out=IDLE_BYTE, valid_out=0.
- With out_ready=0: all outputs, last_grant and the sync counter hold, and no pop occurs. Writes continue.
- Simultaneous push and pop on one lane leave the count unchanged. Pointers are log2(DEPTH) bits and wrap naturally.

## Timing
- Reset values: data_out=IDLE_BYTE, valid_out=0, lane_out=0, active_out=0, drop_cnt=0, counts=0, pointers=0, last_grant=1 (lane 0 wins first tie). ready_out0/1=1 during and after reset.
- Reset asserted mid-operation flushes both FIFOs and returns to SYNC on the next edge.
- active_out rises on the edge after the last SYNC idle cycle. With out_ready held 1, the first possible valid_out=1 is SYNC_CYCLES+1 edges after reset release.
- Latency: a byte sampled at edge k appears on data_out after edge k+1 at the earliest (ACTIVE, out_ready=1, lane granted).
- Throughput is one byte per cycle in total. With both lanes backlogged, lanes alternate strictly.

## Structure
- Shared phy_tx package holds:
  - state enum {SYNC, ACTIVE}
  - IDLE_BYTE default constant
  - DROP_CNT_W=8
- One sub-module, tx_lane_fifo: parameterized DATA_W/DEPTH synchronous FIFO with push, pop, head, count, full, empty. It is instantiated twice.
- Arbiter, FSM and output register live in the top module.

## Test plan
- Reset release, out_ready=1, no input: 4 cycles of data_out=8'hBC, valid_out=0, then active_out=1; data_out stays 8'hBC.
- After ACTIVE, lane0 sends 8'h11, 8'h22 while lane1 sends 8'hA1, 8'hA2 in the same cycles: output is 11(lane0), A1(lane1), 22(lane0), A2(lane1) back to back.
- Lane 0 only sends 8'h01..8'h06 with out_ready=0: ready_out0 falls after 4 writes and drop_cnt=2. Release out_ready: output is 01..04, then idle.
- out_ready toggled 1,0,1 during a lane1 burst: data_out/valid_out hold in the stalled cycle, and no byte is lost or duplicated.
- Reset asserted with 3 bytes queued: FIFOs empty, valid_out=0, drop_cnt=0, the SYNC sequence repeats, and the queued bytes never appear.
- 300 valid bytes driven into a permanently stalled full lane: drop_cnt saturates at 255.
